// File: rtl/ktlink_multi_buf.sv
// Multi-target KT-Link buffer: steers FT2232 JTAG/SWD pins to one of NUM_CH target headers.
// Latency: FT_* to pin data path is combinational; mode/channel/nSRST/TCK controls pass a 2-FF sync.
// Backpressure: none; requests are never dropped, the last synced value wins after the guard interval.
module ktlink_multi_buf #(
    parameter int NUM_CH       = 2,
    parameter int CH_W         = 1,
    parameter int GUARD_CYCLES = 8,
    parameter int SRST_FILT    = 4,
    parameter int LED_HOLD     = 50000
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              FT_SWD_EN,
    input  logic [CH_W-1:0]   FT_CH_SEL,
    input  logic              FT_TCK_OE,
    input  logic              FT_TDI_OE,
    input  logic              FT_TMS_OE,
    input  logic              FT_nTRST_OE,
    input  logic              FT_nSRST_OE,
    input  logic              FT_TCK,
    input  logic              FT_TDI,
    input  logic              FT_TMS,
    input  logic              FT_nTRST_OUT,
    input  logic              FT_nSRST_OUT,
    input  logic              FT_LED_OUT,
    output logic              FT_TDO,
    output logic              FT_RTCK,
    output logic              FT_RX,
    output logic              FT_nSRST_IN,
    output logic [NUM_CH-1:0] TCK,
    output logic [NUM_CH-1:0] TDI,
    output logic [NUM_CH-1:0] nTRST,
    inout  wire  [NUM_CH-1:0] TMS,
    inout  wire  [NUM_CH-1:0] nSRST,
    input  logic [NUM_CH-1:0] TDO,
    input  logic [NUM_CH-1:0] RTCK,
    output logic              LED,
    output logic              MODE_SWD,
    output logic              BUSY
);

    localparam int GCNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam int SCNT_W = $clog2(SRST_FILT) + 1;
    localparam int LCNT_W = $clog2(LED_HOLD + 1);

    typedef enum logic {GUARD = 1'b0, ACTIVE = 1'b1} state_t;

    state_t              state;
    logic [GCNT_W-1:0]   gcnt;
    logic [CH_W-1:0]     cur_ch;
    logic [CH_W-1:0]     pend_ch;
    logic                pend_mode;
    logic [CH_W-1:0]     eff_ch;
    logic [NUM_CH-1:0]   drv;
    logic [1:0]          swd_s;
    logic [CH_W-1:0]     ch_s1;
    logic [CH_W-1:0]     ch_s2;
    logic [1:0]          srst_s;
    logic [2:0]          tck_s;
    logic [SCNT_W-1:0]   scnt;
    logic [LCNT_W-1:0]   hold;
    logic                req_mode;
    logic                tck_rise;
    logic                tms_src;

    // Out-of-range channel numbers fall back to header 0.
    assign eff_ch   = ({1'b0, cur_ch} < (CH_W+1)'(NUM_CH)) ? cur_ch : '0;
    assign req_mode = ~swd_s[1];
    assign tck_rise = tck_s[1] & ~tck_s[2];
    assign tms_src  = MODE_SWD ? FT_TDI : FT_TMS;
    assign BUSY     = (state == GUARD);
    assign LED      = ~FT_LED_OUT | (hold != '0);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            swd_s  <= 2'b11;
            ch_s1  <= '0;
            ch_s2  <= '0;
            srst_s <= 2'b11;
            tck_s  <= 3'b111;
        end else begin
            swd_s  <= {swd_s[0], FT_SWD_EN};
            ch_s1  <= FT_CH_SEL;
            ch_s2  <= ch_s1;
            srst_s <= {srst_s[0], nSRST[eff_ch]};
            tck_s  <= {tck_s[1:0], FT_TCK};
        end
    end

    // Any change of the synced request while guarding restarts the full interval.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= GUARD;
            gcnt      <= GCNT_W'(GUARD_CYCLES - 1);
            cur_ch    <= '0;
            MODE_SWD  <= 1'b0;
            pend_ch   <= '0;
            pend_mode <= 1'b0;
        end else begin
            case (state)
                GUARD: begin
                    if (ch_s2 != pend_ch || req_mode != pend_mode) begin
                        pend_ch   <= ch_s2;
                        pend_mode <= req_mode;
                        gcnt      <= GCNT_W'(GUARD_CYCLES - 1);
                    end else if (gcnt == '0) begin
                        state    <= ACTIVE;
                        cur_ch   <= ch_s2;
                        MODE_SWD <= req_mode;
                    end else begin
                        gcnt <= gcnt - 1'b1;
                    end
                end
                ACTIVE: begin
                    if (ch_s2 != cur_ch || req_mode != MODE_SWD) begin
                        state     <= GUARD;
                        gcnt      <= GCNT_W'(GUARD_CYCLES - 1);
                        pend_ch   <= ch_s2;
                        pend_mode <= req_mode;
                    end
                end
                default: state <= GUARD;
            endcase
        end
    end

    // nSRST deglitch runs only while a channel is live; its output holds across the guard.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            scnt        <= '0;
            FT_nSRST_IN <= 1'b1;
            hold        <= '0;
        end else begin
            if (state != ACTIVE || srst_s[1] == FT_nSRST_IN) begin
                scnt <= '0;
            end else if (scnt == SCNT_W'(SRST_FILT - 1)) begin
                FT_nSRST_IN <= srst_s[1];
                scnt        <= '0;
            end else begin
                scnt <= scnt + 1'b1;
            end

            if (state == ACTIVE && tck_rise) begin
                hold <= LCNT_W'(LED_HOLD);
            end else if (hold != '0) begin
                hold <= hold - 1'b1;
            end
        end
    end

    always_comb begin
        drv = '0;
        if (state == ACTIVE) begin
            drv[eff_ch] = 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_pin
        assign TCK[i]   = (drv[i] && !FT_TCK_OE)   ? FT_TCK       : 1'bz;
        assign TDI[i]   = (drv[i] && !FT_TDI_OE)   ? FT_TDI       : 1'bz;
        assign nTRST[i] = (drv[i] && !FT_nTRST_OE) ? FT_nTRST_OUT : 1'bz;
        assign TMS[i]   = (drv[i] && !FT_TMS_OE)   ? tms_src      : 1'bz;
        assign nSRST[i] = (drv[i] && !FT_nSRST_OE) ? FT_nSRST_OUT : 1'bz;
    end

    // In SWD the bidirectional SWDIO (TMS pin) returns on TDO and the target TDO carries SWO.
    always_comb begin
        FT_TDO  = 1'b1;
        FT_RX   = 1'b1;
        FT_RTCK = 1'b0;
        if (state == ACTIVE) begin
            FT_RTCK = RTCK[eff_ch];
            if (MODE_SWD) begin
                FT_TDO = TMS[eff_ch];
                FT_RX  = TDO[eff_ch];
            end else begin
                FT_TDO = TDO[eff_ch];
            end
        end
    end

endmodule

// File: tb/tb_ktlink_multi_buf.sv
// Bench for ktlink_multi_buf: directed scenarios then random traffic, every cycle
// compared against a cycle-level behavioural model of the buffer.
module tb_ktlink_multi_buf;

    localparam int GUARD_CYCLES = 8;
    localparam int SRST_FILT    = 4;
    localparam int LED_HOLD     = 10;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic       ft_swd_en, ft_tck_oe, ft_tdi_oe, ft_tms_oe, ft_ntrst_oe, ft_nsrst_oe;
    logic [0:0] ft_ch_sel;
    logic       ft_tck, ft_tdi, ft_tms, ft_ntrst_out, ft_nsrst_out, ft_led_out;
    logic [1:0] tdo, rtck;
    logic [1:0] tgt_tms, tgt_srst;
    logic       tgt_srst_en;
    wire        ft_tdo, ft_rtck, ft_rx, ft_nsrst_in, led, mode_swd, busy;
    wire  [1:0] tck, tdi, ntrst, tms, nsrst;

    // Target side: drives TMS only while the adapter has released it, nSRST when enabled.
    assign tms   = ft_tms_oe   ? tgt_tms  : 2'bzz;
    assign nsrst = tgt_srst_en ? tgt_srst : 2'bzz;

    always #5 clk = ~clk;

    ktlink_multi_buf #(
        .NUM_CH(2), .CH_W(1), .GUARD_CYCLES(GUARD_CYCLES),
        .SRST_FILT(SRST_FILT), .LED_HOLD(LED_HOLD)
    ) dut (
        .CLK(clk), .nRST(nrst), .FT_SWD_EN(ft_swd_en), .FT_CH_SEL(ft_ch_sel),
        .FT_TCK_OE(ft_tck_oe), .FT_TDI_OE(ft_tdi_oe), .FT_TMS_OE(ft_tms_oe),
        .FT_nTRST_OE(ft_ntrst_oe), .FT_nSRST_OE(ft_nsrst_oe),
        .FT_TCK(ft_tck), .FT_TDI(ft_tdi), .FT_TMS(ft_tms),
        .FT_nTRST_OUT(ft_ntrst_out), .FT_nSRST_OUT(ft_nsrst_out), .FT_LED_OUT(ft_led_out),
        .FT_TDO(ft_tdo), .FT_RTCK(ft_rtck), .FT_RX(ft_rx), .FT_nSRST_IN(ft_nsrst_in),
        .TCK(tck), .TDI(tdi), .nTRST(ntrst), .TMS(tms), .nSRST(nsrst),
        .TDO(tdo), .RTCK(rtck), .LED(led), .MODE_SWD(mode_swd), .BUSY(busy)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model state: link live or guarding, selected header/mode, deglitched reset, LED time left.
    bit       m_active, m_mode, m_req_swd, m_srst_in;
    bit [0:0] m_cur, m_req_ch;
    int       m_quiet, m_srun, m_led;
    bit [1:0] h_ch, h_swd, h_srst;
    bit [2:0] h_tck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_quiet = 0; m_cur = '0; m_mode = 1'b0;
        m_req_ch = '0; m_req_swd = 1'b1; m_srst_in = 1'b1; m_srun = 0; m_led = 0;
        h_ch = 2'b00; h_swd = 2'b11; h_srst = 2'b11; h_tck = 3'b111;
    endtask

    function automatic bit srst_pin(input bit [0:0] ch);
        if (tgt_srst_en) return tgt_srst[ch];
        return (m_active && !ft_nsrst_oe) ? ft_nsrst_out : 1'b0;
    endfunction

    // Synced view of an input = value applied two clock edges earlier.
    task automatic model_edge();
        bit [0:0] s_ch  = h_ch[1];
        bit       s_swd = h_swd[1];
        bit       s_rst = h_srst[1];
        bit       rise  = h_tck[1] && !h_tck[2];
        bit       pin   = srst_pin(m_cur);
        bit       live  = m_active;

        if (live && rise) m_led = LED_HOLD;
        else if (m_led > 0) m_led--;

        if (!live || s_rst == m_srst_in) m_srun = 0;
        else if (m_srun + 1 == SRST_FILT) begin m_srst_in = s_rst; m_srun = 0; end
        else m_srun++;

        if (live) begin
            if (s_ch != m_cur || s_swd == m_mode) begin
                m_active = 1'b0; m_quiet = 0; m_req_ch = s_ch; m_req_swd = s_swd;
            end
        end else if (s_ch != m_req_ch || s_swd != m_req_swd) begin
            m_req_ch = s_ch; m_req_swd = s_swd; m_quiet = 0;
        end else begin
            m_quiet++;
            if (m_quiet == GUARD_CYCLES) begin
                m_active = 1'b1; m_cur = s_ch; m_mode = !s_swd;
            end
        end

        h_ch   = {h_ch[0], ft_ch_sel};
        h_swd  = {h_swd[0], ft_swd_en};
        h_srst = {h_srst[0], pin};
        h_tck  = {h_tck[1:0], ft_tck};
    endtask

    // A pin counts as "high" only when something actually drives a 1 onto it.
    task automatic check_all();
        logic [1:0] e_tck, e_tdi, e_ntrst, e_tms, e_srst, o_tck, o_tdi, o_ntrst, o_tms, o_srst;
        bit e_tdo, e_rx, e_rtck, d;
        for (int i = 0; i < 2; i++) begin
            d = m_active && (i == int'(m_cur));
            e_tck[i]   = d && !ft_tck_oe && ft_tck;
            e_tdi[i]   = d && !ft_tdi_oe && ft_tdi;
            e_ntrst[i] = d && !ft_ntrst_oe && ft_ntrst_out;
            e_tms[i]   = ft_tms_oe ? tgt_tms[i] : (d && (m_mode ? ft_tdi : ft_tms));
            e_srst[i]  = tgt_srst_en ? tgt_srst[i] : (d && !ft_nsrst_oe && ft_nsrst_out);
            o_tck[i]   = (tck[i] === 1'b1);
            o_tdi[i]   = (tdi[i] === 1'b1);
            o_ntrst[i] = (ntrst[i] === 1'b1);
            o_tms[i]   = (tms[i] === 1'b1);
            o_srst[i]  = (nsrst[i] === 1'b1);
        end
        e_tdo = 1'b1; e_rx = 1'b1; e_rtck = 1'b0;
        if (m_active) begin
            e_rtck = rtck[m_cur];
            if (m_mode) begin
                e_tdo = ft_tms_oe ? tgt_tms[m_cur] : ft_tdi;
                e_rx  = tdo[m_cur];
            end else begin
                e_tdo = tdo[m_cur];
            end
        end
        check("tck_pins",   32'(o_tck),   32'(e_tck));
        check("tdi_pins",   32'(o_tdi),   32'(e_tdi));
        check("ntrst_pins", 32'(o_ntrst), 32'(e_ntrst));
        check("tms_pins",   32'(o_tms),   32'(e_tms));
        check("nsrst_pins", 32'(o_srst),  32'(e_srst));
        check("ft_tdo",     32'(ft_tdo),  32'(e_tdo));
        check("ft_rx",      32'(ft_rx),   32'(e_rx));
        check("ft_rtck",    32'(ft_rtck), 32'(e_rtck));
        check("busy",       32'(busy),    32'(!m_active));
        check("mode_swd",   32'(mode_swd), 32'(m_mode));
        check("nsrst_in",   32'(ft_nsrst_in), 32'(m_srst_in));
        check("led",        32'(led),     32'(!ft_led_out || m_led != 0));
    endtask

    task automatic step();
        @(posedge clk);
        if (nrst) model_edge();
        #1;
        check_all();
    endtask

    task automatic apply_reset();
        #2;
        nrst = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        ft_swd_en = 1'b1; ft_ch_sel = 1'b0;
        ft_tck_oe = 1'b0; ft_tdi_oe = 1'b0; ft_tms_oe = 1'b0; ft_ntrst_oe = 1'b0; ft_nsrst_oe = 1'b1;
        ft_tck = 1'b1; ft_tdi = 1'b1; ft_tms = 1'b1; ft_ntrst_out = 1'b1; ft_nsrst_out = 1'b1;
        ft_led_out = 1'b1; tdo = 2'b00; rtck = 2'b00; tgt_tms = 2'b00;
        tgt_srst = 2'b11; tgt_srst_en = 1'b1;

        // Power-up guard, then JTAG on header 0
        apply_reset();
        repeat (12) step();

        // Channel switch to header 1
        ft_ch_sel = 1'b1;
        repeat (14) begin
            tdo = 2'($urandom); rtck = 2'($urandom);
            step();
        end

        // Switch to SWD
        ft_swd_en = 1'b0;
        repeat (14) begin
            ft_tms_oe = 1'($urandom); tgt_tms = 2'($urandom);
            ft_tdi = 1'($urandom); tdo = 2'($urandom);
            step();
        end
        ft_tms_oe = 1'b0; ft_tdi = 1'b1;

        // nSRST glitch too short, then a real reset pulse
        tgt_srst[1] = 1'b0; repeat (3) step();
        tgt_srst[1] = 1'b1; repeat (8) step();
        tgt_srst[1] = 1'b0; repeat (6) step();
        tgt_srst[1] = 1'b1; repeat (10) step();

        // Adapter drives nSRST itself
        ft_nsrst_out = 1'b1; tgt_srst_en = 1'b0; ft_nsrst_oe = 1'b0;
        repeat (4) step();
        ft_nsrst_oe = 1'b1; tgt_srst_en = 1'b1;
        step();

        // LED stretch, then reset in the middle of a hold
        ft_led_out = 1'b1; ft_tck = 1'b0;
        repeat (4) step();
        ft_tck = 1'b1; step();
        ft_tck = 1'b0; repeat (14) step();
        ft_tck = 1'b1; step();
        ft_tck = 1'b0; repeat (5) step();
        ft_tdi = 1'b1; ft_ntrst_out = 1'b1;
        step();
        apply_reset();
        repeat (12) step();

        // Random traffic
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 11) == 0) ft_tck = ~ft_tck;
            ft_tdi = 1'($urandom); ft_tms = 1'($urandom);
            ft_ntrst_out = 1'($urandom); ft_nsrst_out = 1'($urandom);
            ft_led_out = 1'($urandom);
            ft_tck_oe   = ($urandom_range(0, 3) == 0);
            ft_tdi_oe   = ($urandom_range(0, 3) == 0);
            ft_ntrst_oe = ($urandom_range(0, 3) == 0);
            ft_tms_oe   = 1'($urandom);
            tdo = 2'($urandom); rtck = 2'($urandom); tgt_tms = 2'($urandom);
            for (int i = 0; i < 2; i++)
                if ($urandom_range(0, 5) == 0) tgt_srst[i] = ~tgt_srst[i];
            if ($urandom_range(0, 49) == 0) ft_ch_sel = ~ft_ch_sel;
            if ($urandom_range(0, 59) == 0) ft_swd_en = ~ft_swd_en;
            if (n == 1200) apply_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
